mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter Data_width, default 16, memory word width in bits.
REQ-002 Parameter Addr_width, default 12, memory address width in bits.
REQ-003 Parameter N_CORES, default 8, number of requesting cores (2..8).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  N_CORES  per-core access request, level.
REQ-007 we  input  N_CORES  per-core write enable (1 = write, 0 = read), valid while req is high.
REQ-008 addr  input  N_CORES*Addr_width  per-core address; core i occupies bits [i*Addr_width +: Addr_width].
REQ-009 din  input  N_CORES*Data_width  per-core write data, packed as for addr.
REQ-010 ack  output  N_CORES  per-core completion pulse, one-hot or zero.
REQ-011 rdata  output  Data_width  read data returned to the acknowledged core.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 mem_we  output  1  write enable to the single-port synchronous RAM.
REQ-014 mem_addr  output  Addr_width  RAM address.
REQ-015 mem_din  output  Data_width  RAM write data.
REQ-016 mem_dout  input  Data_width  RAM read data, registered by the RAM one cycle after mem_addr is sampled with mem_we=0.

Function
REQ-017 The FSM SHALL have the states IDLE, ACCESS, CAPTURE and DONE, and all outputs SHALL be registered.
REQ-018 In IDLE with req != 0, the arbiter SHALL grant the first requester at or after ptr, searching upward with wrap from N_CORES-1 to 0.
REQ-019 In IDLE with req == 0, the FSM SHALL stay in IDLE and all memory-side outputs SHALL hold.
REQ-020 On the granting edge, the arbiter SHALL load gnt <= g, ptr <= (g+1) mod N_CORES, mem_addr <= addr[g], mem_din <= din[g] and mem_we <= we[g], and SHALL move to ACCESS.
REQ-021 The RAM SHALL sample the transfer at the edge ending ACCESS; on that edge mem_we SHALL clear to 0.
REQ-022 From ACCESS, the next state SHALL be DONE for a write and CAPTURE for a read.
REQ-023 On the edge ending CAPTURE, the arbiter SHALL load rdata <= mem_dout and move to DONE.
REQ-024 In DONE, ack[gnt] SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-025 Latency, counted from the IDLE grant cycle t: write ack SHALL appear in cycle t+2; read ack SHALL appear in cycle t+3.
REQ-026 rdata SHALL hold its value until the next read completes; writes SHALL NOT alter rdata.
REQ-027 Core handshake: a core SHALL hold req, we, addr and din stable until it samples ack=1, and SHALL clear req on that edge. The arbiter SHALL NOT regrant a core in the IDLE cycle that follows its DONE unless that core has re-raised req.
REQ-028 req changes outside IDLE SHALL be ignored; the latched transfer SHALL NOT change.
REQ-029 mem_we SHALL be 1 only during an ACCESS cycle of a write.
REQ-030 Simultaneous requests SHALL be served one per transaction in round-robin order, with no starvation: each requester SHALL be served within N_CORES transactions.

Reset
REQ-031 When rst_n is low, outputs SHALL clear immediately: state=IDLE, ptr=0, gnt=0, ack=0, busy=0, mem_we=0, mem_addr=0, mem_din=0, rdata=0.
REQ-032 Reset mid-transaction SHALL abort the transaction with no ack. A write whose ACCESS edge is not reached SHALL NOT be performed.
REQ-033 On release of rst_n, the first grant SHALL start from core 0.

Verification
REQ-034 Core 3 writes 0x1234 to 0x0FA: mem_we=1 for one cycle with mem_addr=0x0FA and mem_din=0x1234; ack=8'b0000_1000 in cycle t+2.
REQ-035 Core 3 then reads 0x0FA: mem_we stays 0; rdata=0x1234 and ack[3]=1 together in cycle t+3.
REQ-036 After reset, all 8 cores raise read req together: acks SHALL occur in order 0,1,...,7, each 4 cycles apart, with busy high throughout except the IDLE cycles.
REQ-037 After core 5 is served, cores 2 and 6 request together: core 6 SHALL be granted first, then core 2.
REQ-038 rst_n pulled low during ACCESS of a write to 0x010: mem_we=0 immediately, no ack, and a later read of 0x010 SHALL return the previous contents.
REQ-039 Core 0 issues back-to-back writes, re-raising req after each ack: consecutive grants to core 0 SHALL be 3 cycles apart, with exactly one ack per write.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter giving N_CORES cores shared access to one
// single-port synchronous RAM. One transfer at a time:
//   IDLE -> ACCESS -> (read) CAPTURE -> DONE -> IDLE
//   IDLE -> ACCESS -> (write)           DONE -> IDLE
// All outputs are registered.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   req/we [N]        per-core request level and write enable
//   addr/din          per-core address / write data, core i at [i*W +: W]
//   ack [N]           one-cycle completion pulse to the served core (DONE)
//   rdata             read data of the most recent completed read
//   busy              high whenever the FSM is not in IDLE
//   mem_we/addr/din   RAM request side; mem_dout RAM registered read data
module mem_arbiter #(
  parameter int Data_width = 16,
  parameter int Addr_width = 12,
  parameter int N_CORES    = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_CORES-1:0]             req,
  input  logic [N_CORES-1:0]             we,
  input  logic [N_CORES*Addr_width-1:0]  addr,
  input  logic [N_CORES*Data_width-1:0]  din,
  output logic [N_CORES-1:0]             ack,
  output logic [Data_width-1:0]          rdata,
  output logic                           busy,
  output logic                           mem_we,
  output logic [Addr_width-1:0]          mem_addr,
  output logic [Data_width-1:0]          mem_din,
  input  logic [Data_width-1:0]          mem_dout
);

  localparam int GW = $clog2(N_CORES);
  localparam logic [N_CORES-1:0] ONE = N_CORES'(1);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] ptr, gnt, g_sel;

  // Round-robin pick: first requester at or after ptr, wrapping. Scanning the
  // offsets from high to low lets the smallest offset win.
  always_comb begin
    int idx;
    g_sel = '0;
    for (int k = N_CORES - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_CORES) idx = idx - N_CORES;
      if (req[idx]) g_sel = GW'(idx);
    end
  end

  // Next state. During ACCESS mem_we still holds the latched write enable,
  // so it doubles as the read/write flag for the transfer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = ACCESS;
      ACCESS:  state_nxt = mem_we ? DONE : CAPTURE;
      CAPTURE: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt      <= '0;
      ack      <= '0;
      busy     <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      rdata    <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      ack   <= '0;  // ack is a single-cycle pulse, raised on the edge into DONE
      case (state)
        IDLE: begin
          // With no request the memory-side registers simply hold.
          if (|req) begin
            gnt      <= g_sel;
            ptr      <= (int'(g_sel) == N_CORES - 1) ? '0 : g_sel + 1'b1;
            mem_addr <= addr[int'(g_sel)*Addr_width +: Addr_width];
            mem_din  <= din[int'(g_sel)*Data_width +: Data_width];
            mem_we   <= we[g_sel];
          end
        end
        ACCESS: begin
          // RAM samples the transfer on this edge; write strobe lasts one cycle.
          mem_we <= 1'b0;
          if (mem_we) ack <= ONE << gnt;
        end
        CAPTURE: begin
          rdata <= mem_dout;
          ack   <= ONE << gnt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int NC = 8, AW = 12, DW = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NC-1:0]    req = '0, we = '0;
  logic [NC*AW-1:0] addr = '0;
  logic [NC*DW-1:0] din = '0;
  logic [NC-1:0]    ack;
  logic [DW-1:0]    rdata, mem_din, mem_dout;
  logic [AW-1:0]    mem_addr;
  logic             busy, mem_we;

  mem_arbiter #(.Data_width(DW), .Addr_width(AW), .N_CORES(NC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .din(din),
    .ack(ack), .rdata(rdata), .busy(busy), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout));

  // single-port synchronous RAM
  logic [DW-1:0] ram [4096] = '{default: '0};
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    else        mem_dout <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus data + reference model ----------------
  typedef struct { bit wr; int a; int d; } job_t;
  typedef struct { int core; bit wr; int rd; int cyc; } exp_t;
  typedef struct { int a; int d; } mw_t;

  job_t jobs [NC][4];
  int   njob [NC];
  int   jidx [NC];
  exp_t eq [$];
  mw_t  mq [$];
  int   gq [$];
  int   shadow [4096];
  int   ptr_m = 0;
  int   to_cnt = 0;
  bit   fin = 1'b0;

  task automatic clear_jobs();
    for (int i = 0; i < NC; i++) begin njob[i] = 0; jidx[i] = 0; end
    req = '0;
  endtask

  task automatic add_job(input int c, input bit wr, input int a, input int d);
    jobs[c][njob[c]].wr = wr;
    jobs[c][njob[c]].a  = a;
    jobs[c][njob[c]].d  = d;
    njob[c]++;
  endtask

  task automatic present(input int i);
    if (jidx[i] < njob[i]) begin
      req[i] = 1'b1;
      we[i]  = jobs[i][jidx[i]].wr;
      addr[i*AW +: AW] = AW'(jobs[i][jidx[i]].a);
      din[i*DW +: DW]  = DW'(jobs[i][jidx[i]].d);
    end else begin
      req[i] = 1'b0;
    end
  endtask

  function automatic bit pending();
    pending = 1'b0;
    for (int i = 0; i < NC; i++) if (jidx[i] < njob[i]) pending = 1'b1;
  endfunction

  // Transaction-level prediction: every core with jobs left keeps requesting
  // (a served core re-presents its next job at once). Each transfer starts in
  // an idle grant cycle; a write takes 3 cycles (ack at +2), a read 4 (ack at +3).
  task automatic model();
    int pos [NC];
    int t, g, c;
    exp_t e;
    mw_t m;
    t = cyc;
    for (int i = 0; i < NC; i++) pos[i] = jidx[i];
    forever begin
      g = -1;
      for (int k = 0; k < NC; k++) begin
        c = (ptr_m + k) % NC;
        if (g < 0 && pos[c] < njob[c]) g = c;
      end
      if (g < 0) break;
      gq.push_back(t);
      e.core = g; e.wr = jobs[g][pos[g]].wr;
      if (e.wr) begin
        shadow[jobs[g][pos[g]].a] = jobs[g][pos[g]].d;
        m.a = jobs[g][pos[g]].a; m.d = jobs[g][pos[g]].d;
        mq.push_back(m);
        e.rd = 0; e.cyc = t + 2; t += 3;
      end else begin
        e.rd = shadow[jobs[g][pos[g]].a]; e.cyc = t + 3; t += 4;
      end
      eq.push_back(e);
      pos[g]++;
      ptr_m = (g + 1) % NC;
    end
  endtask

  // One clock: note acks mid-cycle, then just after the edge retire acked
  // jobs and present each core's next one (or drop req).
  task automatic tick();
    logic [NC-1:0] av;
    @(negedge clk);
    av = ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++) if (av[i]) begin jidx[i]++; present(i); end
  endtask

  task automatic run_batch();
    int n;
    model();
    for (int i = 0; i < NC; i++) present(i);
    n = 0;
    while ((pending() || eq.size() != 0) && n < 600) begin tick(); n++; end
    if (n >= 600) begin
      to_cnt++;
      eq.delete(); mq.delete(); gq.delete();
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int n_chk = 0, n_pass = 0, to_seen = 0;
  bit fin_done = 1'b0;

  task automatic chk(input bit ok, input string nm, input longint act, input longint ex);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, ex, cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    mw_t m;
    int g;
    logic [NC-1:0] ea;
    if (!rst_n) begin
      chk(ack == '0,      "rst_ack",      ack, 0);
      chk(busy == 1'b0,   "rst_busy",     busy, 0);
      chk(mem_we == 1'b0, "rst_mem_we",   mem_we, 0);
      chk(mem_addr == '0, "rst_mem_addr", mem_addr, 0);
      chk(mem_din == '0,  "rst_mem_din",  mem_din, 0);
      chk(rdata == '0,    "rst_rdata",    rdata, 0);
    end else begin
      while (gq.size() > 0 && gq[0] < cyc) g = gq.pop_front();
      if (gq.size() > 0 && gq[0] == cyc) begin
        chk(busy == 1'b0, "grant_cycle_busy", busy, 0);
        g = gq.pop_front();
      end
      if (ack != '0) begin
        if (eq.size() == 0) chk(1'b0, "unexpected_ack", ack, 0);
        else begin
          e = eq.pop_front();
          ea = '0; ea[e.core] = 1'b1;
          chk(ack == ea,    "ack_core",  ack, ea);
          chk(cyc == e.cyc, "ack_cycle", cyc, e.cyc);
          chk(busy == 1'b1, "ack_busy",  busy, 1);
          if (!e.wr) chk(int'(rdata) == e.rd, "rdata", rdata, e.rd);
        end
      end
      if (mem_we) begin
        if (mq.size() == 0) chk(1'b0, "unexpected_mem_we", mem_addr, 0);
        else begin
          m = mq.pop_front();
          chk(int'(mem_addr) == m.a, "mem_addr", mem_addr, m.a);
          chk(int'(mem_din) == m.d,  "mem_din",  mem_din, m.d);
        end
      end
    end
    if (to_cnt != to_seen) begin
      chk(1'b0, "timeout", to_cnt, to_seen);
      to_seen = to_cnt;
    end
    if (fin && !fin_done) begin
      fin_done = 1'b1;
      chk(eq.size() == 0, "acks_outstanding", eq.size(), 0);
      chk(mq.size() == 0, "writes_outstanding", mq.size(), 0);
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < 4096; i++) shadow[i] = 0;
    clear_jobs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // all cores read together after reset: served 0..7, 4 cycles apart
    for (int i = 0; i < NC; i++) add_job(i, 1'b0, i, 0);
    run_batch(); clear_jobs();

    // core 3 write then read back 0x0FA
    add_job(3, 1'b1, 'h0FA, 'h1234); run_batch(); clear_jobs();
    add_job(3, 1'b0, 'h0FA, 0);      run_batch(); clear_jobs();

    // core 5, then 2 and 6 together
    add_job(5, 1'b0, 'h0FA, 0);      run_batch(); clear_jobs();
    add_job(2, 1'b1, 'h020, 'h2222);
    add_job(6, 1'b1, 'h060, 'h6666); run_batch(); clear_jobs();

    // core 0 back-to-back writes
    for (int k = 0; k < 4; k++) add_job(0, 1'b1, 'h100 + k, 'hC000 + k);
    run_batch(); clear_jobs();

    // reset during ACCESS of a write: aborted, RAM keeps old data
    add_job(1, 1'b1, 'h010, 'hAAAA); run_batch(); clear_jobs();
    add_job(2, 1'b1, 'h010, 'h5555);
    present(2);            // deliberately not modelled: it must never complete
    tick();                // now in the ACCESS cycle
    rst_n = 1'b0;
    clear_jobs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    ptr_m = 0;
    add_job(5, 1'b0, 'h010, 0);
    add_job(7, 1'b1, 'h011, 'h7777);
    add_job(0, 1'b0, 'h010, 0);
    run_batch(); clear_jobs();

    // randomized batches
    for (int b = 0; b < 30; b++) begin
      for (int i = 0; i < NC; i++)
        if ($urandom_range(1, 0) == 1) begin
          int nj;
          nj = $urandom_range(3, 1);
          for (int k = 0; k < nj; k++)
            add_job(i, 1'($urandom_range(1, 0)), $urandom_range(15, 0),
                    $urandom_range(16'hFFFF, 0));
        end
      if (!pending()) add_job(0, 1'b0, $urandom_range(15, 0), 0);
      run_batch(); clear_jobs();
      repeat ($urandom_range(2, 0)) tick();
    end

    fin = 1'b1;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
